// File: rtl/q_mult.sv
// q_mult: sequential signed fixed-point multiplier. It is the per-channel
// product element of the pointwise convolution unit.
//
// The unit takes one pair of N-bit two's-complement operands and returns
// their exact product, sign-extended to 32 bits. It works on the operand
// magnitudes with a shift-add loop that retires one multiplier bit per
// cycle, then applies the sign at the end.
//
// Timing with ce held high: operands accepted at edge t0 give a new
// product_dout and a one-cycle product_dout_vld at edge t0+N.
//
// Ports:
//   clk               in   clock, rising edge
//   rst_n             in   synchronous active-low reset (overrides ce)
//   ce                in   clock enable; low freezes all state and outputs
//   input_vld         in   operand strobe, taken in IDLE or DONE
//   multiplicand_din  in   [N-1:0] signed operand A
//   multiplier_din    in   [N-1:0] signed operand B
//   product_dout      out  [31:0] A*B sign-extended, held until next result
//   product_dout_vld  out  one-cycle pulse when product_dout is new
//   product_end       out  high from completion until the next accept
//
// Legal N is 2..16, so that the 2N-bit product fits in 32 bits.
module q_mult #(
    parameter int N = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          input_vld,
    input  logic [N-1:0]  multiplicand_din,
    input  logic [N-1:0]  multiplier_din,
    output logic [31:0]   product_dout,
    output logic          product_dout_vld,
    output logic          product_end
);

    localparam int W2 = 2 * N;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [W2-1:0]   mcand_q, mcand_d;   // multiplicand magnitude, shifted left each step
    logic [N-1:0]    mplier_q, mplier_d; // multiplier magnitude, shifted right each step
    logic            neg_q, neg_d;
    logic [31:0]     dout_q, dout_d;
    logic            vld_q, vld_d;
    logic            end_q, end_d;

    logic [N-1:0]    a_mag;
    logic [N-1:0]    b_mag;
    logic [W2-1:0]   addend;
    logic [W2-1:0]   acc_sum;
    logic [W2-1:0]   res_signed;
    logic            accept;

    // Magnitudes are N-bit unsigned. For -2^(N-1), negation wraps back to
    // 2^(N-1), and that value is exactly the right unsigned magnitude.
    always_comb begin
        a_mag = multiplicand_din;
        b_mag = multiplier_din;
        if (multiplicand_din[N-1]) a_mag = ~multiplicand_din + N'(1);
        if (multiplier_din[N-1])   b_mag = ~multiplier_din + N'(1);
    end

    assign accept = input_vld && (state_q == IDLE || state_q == DONE);

    // One shift-add step. On the last step the sum is used directly, so
    // the result is ready at the same edge that retires the final bit.
    assign addend     = mplier_q[0] ? mcand_q : '0;
    assign acc_sum    = acc_q + addend;
    assign res_signed = neg_q ? (~acc_sum + W2'(1)) : acc_sum;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        dout_d   = dout_q;
        vld_d    = 1'b0;
        end_d    = end_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d  = BUSY;
                    cnt_d    = CW'(N);
                    acc_d    = '0;
                    mcand_d  = {{N{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = multiplicand_din[N-1] ^ multiplier_din[N-1];
                    end_d    = 1'b0;
                end
            end
            BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    dout_d  = 32'($signed(res_signed));
                    vld_d   = 1'b1;
                    end_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset wins over ce. With ce low everything holds, and that includes
    // a pending vld pulse, which then stays high until ce returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            end_q    <= 1'b0;
        end else if (ce) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            end_q    <= end_d;
        end
    end

    assign product_dout     = dout_q;
    assign product_dout_vld = vld_q;
    assign product_end      = end_q;

endmodule

// File: tb/tb_q_mult.sv
module tb_q_mult;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          input_vld;
    logic [N-1:0]  multiplicand_din;
    logic [N-1:0]  multiplier_din;
    logic [31:0]   product_dout;
    logic          product_dout_vld;
    logic          product_end;

    int total = 0;
    int bad   = 0;

    q_mult #(.N(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ce               (ce),
        .input_vld        (input_vld),
        .multiplicand_din (multiplicand_din),
        .multiplier_din   (multiplier_din),
        .product_dout     (product_dout),
        .product_dout_vld (product_dout_vld),
        .product_end      (product_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one operand pair for a single edge. The caller then sits
    // just after the accept edge, t0.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        multiplicand_din = a;
        multiplier_din   = b;
        input_vld        = 1'b1;
        step();
        input_vld        = 1'b0;
    endtask

    // Step until vld is seen, giving up after a bounded number of edges.
    task automatic wait_vld(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!product_dout_vld && cycles < 100);
    endtask

    initial begin
        int cyc;
        int pulses;
        logic [15:0] ra, rb;
        logic [31:0] rexp;

        vecs[0] = '{16'd3,      16'd4,      32'h0000000C};
        vecs[1] = '{16'hFFFD,   16'd4,      32'hFFFFFFF4};
        vecs[2] = '{16'h8000,   16'h8000,   32'h40000000};
        vecs[3] = '{16'h7FFF,   16'h8000,   32'hC0008000};
        vecs[4] = '{16'd0,      16'hFFFF,   32'h00000000};
        vecs[5] = '{16'hFFFF,   16'hFFFF,   32'h00000001};
        vecs[6] = '{16'h7FFF,   16'h7FFF,   32'h3FFF0001};
        vecs[7] = '{16'h8000,   16'd1,      32'hFFFF8000};
        vecs[8] = '{16'd1234,   16'hFDC9,   32'hFFF552E2};  // 1234 * -567

        rst_n = 1'b0; ce = 1'b1; input_vld = 1'b0;
        multiplicand_din = '0; multiplier_din = '0;
        step(); step();
        chk("reset_dout", product_dout, 32'h0);
        chk("reset_vld",  {31'b0, product_dout_vld}, 32'h0);
        chk("reset_end",  {31'b0, product_end}, 32'h0);
        rst_n = 1'b1;
        step();

        // Directed vectors: latency, value, pulse width, sticky end
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b);
            chk("vec_end_cleared", {31'b0, product_end}, 32'h0);
            wait_vld(cyc);
            chk("vec_latency", 32'(cyc), 32'(N));
            chk("vec_dout", product_dout, vecs[i].exp);
            chk("vec_end_set", {31'b0, product_end}, 32'h1);
            step();
            chk("vec_vld_drop", {31'b0, product_dout_vld}, 32'h0);
            step(); step();
            chk("vec_end_sticky", {31'b0, product_end}, 32'h1);
            chk("vec_dout_held", product_dout, vecs[i].exp);
        end

        // Back-to-back random pairs, each new accept issued in the DONE cycle
        ra = 16'($urandom); rb = 16'($urandom);
        issue(ra, rb);
        for (int i = 0; i < 1000; i++) begin
            rexp = 32'($signed(ra) * $signed(rb));
            wait_vld(cyc);
            chk("rnd_latency", 32'(cyc), 32'(N));
            chk("rnd_dout", product_dout, rexp);
            if (i < 999) begin
                ra = 16'($urandom); rb = 16'($urandom);
                issue(ra, rb);
                chk("rnd_vld_drop", {31'b0, product_dout_vld}, 32'h0);
            end
        end
        step(); step();

        // input_vld held through BUSY with changing operands: ignored
        issue(16'd100, 16'hFFF9);   // 100 * -7
        input_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            multiplicand_din = 16'(i * 37 + 5);
            multiplier_din   = 16'(i * 11 + 3);
            step();
        end
        input_vld = 1'b0;
        cyc = 10;
        do begin
            step();
            cyc++;
        end while (!product_dout_vld && cyc < 100);
        chk("busy_ign_latency", 32'(cyc), 32'(N));
        chk("busy_ign_dout", product_dout, 32'hFFFFFD44);
        step(); step();

        // ce low for 5 cycles mid-BUSY stretches latency by exactly 5
        issue(16'd5, 16'hFFFA);     // 5 * -6
        cyc = 0;
        for (int i = 0; i < 5; i++) begin step(); cyc++; end
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); cyc++; end
        ce = 1'b1;
        while (!product_dout_vld && cyc < 100) begin step(); cyc++; end
        chk("ce_latency", 32'(cyc), 32'(N + 5));
        chk("ce_dout", product_dout, 32'hFFFFFFE2);
        // ce low during DONE holds the pulse
        ce = 1'b0;
        step(); step(); step();
        chk("ce_vld_hold", {31'b0, product_dout_vld}, 32'h1);
        chk("ce_dout_hold", product_dout, 32'hFFFFFFE2);
        ce = 1'b1;
        step();
        chk("ce_vld_release", {31'b0, product_dout_vld}, 32'h0);
        step();

        // Reset mid-BUSY aborts the operation
        issue(16'd9, 16'd9);
        step(); step(); step(); step();
        rst_n = 1'b0;
        step();
        chk("rst_mid_dout", product_dout, 32'h0);
        chk("rst_mid_vld",  {31'b0, product_dout_vld}, 32'h0);
        chk("rst_mid_end",  {31'b0, product_end}, 32'h0);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (product_dout_vld) pulses++;
        end
        chk("rst_no_pulse", 32'(pulses), 32'h0);
        issue(16'd7, 16'hFFF8);     // 7 * -8
        wait_vld(cyc);
        chk("post_rst_latency", 32'(cyc), 32'(N));
        chk("post_rst_dout", product_dout, 32'hFFFFFFC8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
